sdram_arbiter: RTL and testbench

- Sits directly downstream of the init, refresh, write and read stages, and directly upstream of the SDRAM pins.
- Grants exclusive bus ownership to one stage at a time, using the per-stage request/enable/end handshakes.
- Multiplexes the owning stage's command, address, bank and write data onto the SDRAM pins.
- Priority order is refresh > write > read.

---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_pin_drv.sv | 113 +++++++++++
 rtl/sdram_arbiter.sv | 127 ++++++++++++
 tb/tb_sdram_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM controller slice: command encodings,
// arbiter state encodings and default widths.
package sdram_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int BANK_W_DEF = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    // One-hot arbiter states; kept as plain vectors so illegal codes are representable.
    localparam int ST_W = 5;
    localparam logic [ST_W-1:0] S_INIT = 5'b00001;
    localparam logic [ST_W-1:0] S_ARB  = 5'b00010;
    localparam logic [ST_W-1:0] S_AREF = 5'b00100;
    localparam logic [ST_W-1:0] S_WR   = 5'b01000;
    localparam logic [ST_W-1:0] S_RD   = 5'b10000;

endpackage

// File: rtl/sdram_pin_drv.sv
// State-selected multiplexer onto the SDRAM pins.
// Optional pin register enabled by the SDRAM_OUT_REG_EN macro (+1 cycle pin latency).
module sdram_pin_drv
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BANK_W = BANK_W_DEF
) (
`ifdef SDRAM_OUT_REG_EN
    input  logic              sclk,
    input  logic              s_rst,
`endif
    input  logic [ST_W-1:0]   state_i,
    input  logic [3:0]        init_cmd_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [3:0]        ref_cmd_i,
    input  logic [ADDR_W-1:0] ref_addr_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [BANK_W-1:0] wr_bank_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [3:0]        rd_cmd_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [BANK_W-1:0] rd_bank_i,
    output logic              sdram_cke_o,
    output logic [3:0]        sdram_cmd_o,
    output logic [BANK_W-1:0] sdram_bank_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    output logic [DATA_W-1:0] sdram_dq_out_o,
    output logic              sdram_dq_oe_o
);

    logic [3:0]        cmd_d;
    logic [BANK_W-1:0] bank_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dq_d;
    logic              oe_d;

    assign sdram_cke_o = 1'b1;

    // Select the owning stage's command/address/data; anything unowned drives an idle NOP.
    always_comb begin
        cmd_d  = CMD_NOP;
        bank_d = {BANK_W{1'b0}};
        addr_d = {ADDR_W{1'b0}};
        dq_d   = {DATA_W{1'b0}};
        oe_d   = 1'b0;
        case (state_i)
            S_INIT: begin
                cmd_d  = init_cmd_i;
                addr_d = init_addr_i;
            end
            S_AREF: begin
                cmd_d  = ref_cmd_i;
                addr_d = ref_addr_i;
            end
            S_WR: begin
                cmd_d  = wr_cmd_i;
                addr_d = wr_addr_i;
                bank_d = wr_bank_i;
                dq_d   = wr_data_i;
                oe_d   = 1'b1;
            end
            S_RD: begin
                cmd_d  = rd_cmd_i;
                addr_d = rd_addr_i;
                bank_d = rd_bank_i;
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

`ifdef SDRAM_OUT_REG_EN
    logic [3:0]        cmd_q;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_q;
    logic              oe_q;

    // Pin register; reset values match the idle/NOP pin state.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            cmd_q  <= CMD_NOP;
            bank_q <= {BANK_W{1'b0}};
            addr_q <= {ADDR_W{1'b0}};
            dq_q   <= {DATA_W{1'b0}};
            oe_q   <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            bank_q <= bank_d;
            addr_q <= addr_d;
            dq_q   <= dq_d;
            oe_q   <= oe_d;
        end
    end

    assign sdram_cmd_o    = cmd_q;
    assign sdram_bank_o   = bank_q;
    assign sdram_addr_o   = addr_q;
    assign sdram_dq_out_o = dq_q;
    assign sdram_dq_oe_o  = oe_q;
`else
    assign sdram_cmd_o    = cmd_d;
    assign sdram_bank_o   = bank_d;
    assign sdram_addr_o   = addr_d;
    assign sdram_dq_out_o = dq_d;
    assign sdram_dq_oe_o  = oe_d;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Bus arbiter between the init, refresh, write and read stages (refresh > write > read).
// Build option SDRAM_OUT_REG_EN registers the sdram_* pins inside sdram_pin_drv.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BANK_W = BANK_W_DEF
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              ref_req,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              flag_ref_end,
    output logic              ref_en,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_wr_end,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic              flag_rd_end,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic [3:0]      pin_cmd_s;

    // State register.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: owners only leave on their own end flag, always via one S_ARB cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
                if (init_end) state_d = S_ARB;
                else          state_d = S_INIT;
            end
            S_ARB: begin
                if (ref_req)     state_d = S_AREF;
                else if (wr_req) state_d = S_WR;
                else if (rd_req) state_d = S_RD;
                else             state_d = S_ARB;
            end
            S_AREF: begin
                if (flag_ref_end) state_d = S_ARB;
                else              state_d = S_AREF;
            end
            S_WR: begin
                if (flag_wr_end) state_d = S_ARB;
                else             state_d = S_WR;
            end
            S_RD: begin
                if (flag_rd_end) state_d = S_ARB;
                else             state_d = S_RD;
            end
            default: begin
                state_d = S_ARB;
            end
        endcase
    end

    // Grants decode straight from state so they fall with the asynchronous reset.
    always_comb begin
        ref_en = (state_q == S_AREF);
        wr_en  = (state_q == S_WR);
        rd_en  = (state_q == S_RD);
    end

    sdram_pin_drv #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BANK_W (BANK_W)
    ) u_pin_drv (
`ifdef SDRAM_OUT_REG_EN
        .sclk           (sclk),
        .s_rst          (s_rst),
`endif
        .state_i        (state_q),
        .init_cmd_i     (init_cmd),
        .init_addr_i    (init_addr),
        .ref_cmd_i      (ref_cmd),
        .ref_addr_i     (ref_addr),
        .wr_cmd_i       (wr_cmd),
        .wr_addr_i      (wr_addr),
        .wr_bank_i      (wr_bank),
        .wr_data_i      (wr_data),
        .rd_cmd_i       (rd_cmd),
        .rd_addr_i      (rd_addr),
        .rd_bank_i      (rd_bank),
        .sdram_cke_o    (sdram_cke),
        .sdram_cmd_o    (pin_cmd_s),
        .sdram_bank_o   (sdram_bank),
        .sdram_addr_o   (sdram_addr),
        .sdram_dq_out_o (sdram_dq_out),
        .sdram_dq_oe_o  (sdram_dq_oe)
    );

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd_s;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus random traffic
// against a bus-ownership reference model (honours SDRAM_OUT_REG_EN pin latency).
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int BW = 2;

    localparam int O_INIT = 0;
    localparam int O_ARB  = 1;
    localparam int O_REF  = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    localparam logic [34:0] PINS_RST = {4'b0111, 2'b00, 12'h000, 16'h0000, 1'b0};

    logic          sclk = 1'b0;
    logic          s_rst;
    logic [3:0]    init_cmd;
    logic [AW-1:0] init_addr;
    logic          init_end;
    logic          ref_req;
    logic [3:0]    ref_cmd;
    logic [AW-1:0] ref_addr;
    logic          flag_ref_end;
    logic          ref_en;
    logic          wr_req;
    logic [3:0]    wr_cmd;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_bank;
    logic [DW-1:0] wr_data;
    logic          flag_wr_end;
    logic          wr_en;
    logic          rd_req;
    logic [3:0]    rd_cmd;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_bank;
    logic          flag_rd_end;
    logic          rd_en;
    logic          sdram_cke;
    logic          sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BW-1:0] sdram_bank;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_dq_out;
    logic          sdram_dq_oe;

    logic [34:0] dut_pins;
    assign dut_pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                       sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe};

    int          own;
    logic [34:0] pin_q_m;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 sclk = ~sclk;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BANK_W(BW)) dut (
        .sclk(sclk), .s_rst(s_rst),
        .init_cmd(init_cmd), .init_addr(init_addr), .init_end(init_end),
        .ref_req(ref_req), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .flag_ref_end(flag_ref_end), .ref_en(ref_en),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .wr_data(wr_data), .flag_wr_end(flag_wr_end), .wr_en(wr_en),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .flag_rd_end(flag_rd_end), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_bank(sdram_bank),
        .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    // What the pins should show for a given bus owner with the current stage inputs.
    function automatic logic [34:0] pins_for(int o);
        case (o)
            O_INIT:  return {init_cmd, 2'b00, init_addr, 16'h0000, 1'b0};
            O_REF:   return {ref_cmd, 2'b00, ref_addr, 16'h0000, 1'b0};
            O_WR:    return {wr_cmd, wr_bank, wr_addr, wr_data, 1'b1};
            O_RD:    return {rd_cmd, rd_bank, rd_addr, 16'h0000, 1'b0};
            default: return PINS_RST;
        endcase
    endfunction

    // Ownership rules: init until init_end, arbitration by priority, owners hold until their own end flag.
    function automatic int next_own(int o);
        int prio_owner[3];
        logic prio_req[3];
        prio_owner = '{O_REF, O_WR, O_RD};
        prio_req   = '{ref_req, wr_req, rd_req};
        case (o)
            O_INIT: return init_end ? O_ARB : O_INIT;
            O_ARB: begin
                for (int i = 0; i < 3; i++) if (prio_req[i]) return prio_owner[i];
                return O_ARB;
            end
            O_REF:   return flag_ref_end ? O_ARB : O_REF;
            O_WR:    return flag_wr_end ? O_ARB : O_WR;
            O_RD:    return flag_rd_end ? O_ARB : O_RD;
            default: return O_ARB;
        endcase
    endfunction

    function automatic logic [34:0] exp_pins();
`ifdef SDRAM_OUT_REG_EN
        return pin_q_m;
`else
        return pins_for(own);
`endif
    endfunction

    function automatic logic [2:0] exp_grants();
        return {own == O_REF, own == O_WR, own == O_RD};
    endfunction

    // Move the model and the DUT across one rising edge; inputs may change afterwards.
    task automatic advance();
        @(posedge sclk);
        if (s_rst) begin
            own     = O_INIT;
            pin_q_m = PINS_RST;
        end else begin
            pin_q_m = pins_for(own);
            own     = next_own(own);
        end
        #1;
    endtask

    task automatic idle_inputs();
        init_end = 1'b0; ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
    endtask

    task automatic randomize_payload();
        ref_cmd  = 4'($urandom); ref_addr = 12'($urandom);
        wr_cmd   = 4'($urandom); wr_addr  = 12'($urandom);
        wr_bank  = 2'($urandom); wr_data  = 16'($urandom);
        rd_cmd   = 4'($urandom); rd_addr  = 12'($urandom);
        rd_bank  = 2'($urandom);
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        idle_inputs();
        init_cmd = CMD_NOP; init_addr = 12'h000;
        randomize_payload();
        own = O_INIT; pin_q_m = PINS_RST;
        repeat (3) advance();
        @(negedge sclk);
        n_checks++;
        if ({ref_en, wr_en, rd_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_grants got %b want 000", {ref_en, wr_en, rd_en});
        end
        n_checks++;
        if (dut_pins !== PINS_RST) begin
            n_fail++; $display("FAIL reset_pins got %h want %h", dut_pins, PINS_RST);
        end
        n_checks++;
        if (sdram_cke !== 1'b1) begin
            n_fail++; $display("FAIL reset_cke got %b want 1", sdram_cke);
        end
        advance();
        s_rst = 1'b0;
    endtask

    task automatic test_init();
        for (int c = 0; c <= 12; c++) begin
            init_cmd  = 4'($urandom);
            init_addr = 12'($urandom);
            init_end  = (c == 10);
            wr_req    = (c == 3);
            ref_req   = (c == 5);
            randomize_payload();
            @(negedge sclk);
            n_checks++;
            if ({ref_en, wr_en, rd_en} !== 3'b000) begin
                n_fail++; $display("FAIL init_grants c=%0d got %b want 000", c, {ref_en, wr_en, rd_en});
            end
            n_checks++;
            if (dut_pins !== exp_pins()) begin
                n_fail++; $display("FAIL init_pins c=%0d got %h want %h", c, dut_pins, exp_pins());
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_write();
        int wr_cycles = 0;
        int first_c   = -1;
        for (int c = 0; c <= 23; c++) begin
            wr_req      = (c == 0);
            flag_wr_end = (c == 20);
            randomize_payload();
            @(negedge sclk);
            if (wr_en === 1'b1) begin
                wr_cycles++;
                if (first_c < 0) first_c = c;
            end
            n_checks++;
            if ({ref_en, wr_en, rd_en} !== exp_grants()) begin
                n_fail++; $display("FAIL write_grants c=%0d got %b want %b", c, {ref_en, wr_en, rd_en}, exp_grants());
            end
            n_checks++;
            if (dut_pins !== exp_pins()) begin
                n_fail++; $display("FAIL write_pins c=%0d got %h want %h", c, dut_pins, exp_pins());
            end
            advance();
        end
        idle_inputs();
        n_checks++;
        if (wr_cycles != 20) begin
            n_fail++; $display("FAIL write_len got %0d want 20", wr_cycles);
        end
        n_checks++;
        if (first_c != 1) begin
            n_fail++; $display("FAIL write_first got %0d want 1", first_c);
        end
    endtask

    task automatic test_priority();
        logic [2:0] seen_g[$];
        int         seen_c[$];
        logic [2:0] prev_g = 3'b000;
        logic [2:0] want_g[3];
        int         want_c[3];
        want_g = '{3'b100, 3'b010, 3'b001};
        want_c = '{1, 7, 12};
        for (int c = 0; c <= 17; c++) begin
            ref_req = (c < 5);  flag_ref_end = (c == 5);
            wr_req  = (c < 10); flag_wr_end  = (c == 10);
            rd_req  = (c < 14); flag_rd_end  = (c == 14);
            randomize_payload();
            @(negedge sclk);
            if ({ref_en, wr_en, rd_en} != 3'b000 && {ref_en, wr_en, rd_en} != prev_g) begin
                seen_g.push_back({ref_en, wr_en, rd_en});
                seen_c.push_back(c);
            end
            prev_g = {ref_en, wr_en, rd_en};
            n_checks++;
            if (dut_pins !== exp_pins()) begin
                n_fail++; $display("FAIL prio_pins c=%0d got %h want %h", c, dut_pins, exp_pins());
            end
            advance();
        end
        idle_inputs();
        n_checks++;
        if (seen_g.size() != 3) begin
            n_fail++; $display("FAIL prio_count got %0d want 3", seen_g.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (seen_g[i] !== want_g[i] || seen_c[i] != want_c[i]) begin
                    n_fail++;
                    $display("FAIL prio_order idx=%0d got %b@%0d want %b@%0d", i, seen_g[i], seen_c[i], want_g[i], want_c[i]);
                end
            end
        end
    endtask

    task automatic test_preempt();
        for (int c = 0; c <= 15; c++) begin
            wr_req       = (c == 0) || (c >= 5 && c < 13);
            ref_req      = (c >= 4 && c < 9);
            flag_wr_end  = (c == 5) || (c == 13);
            flag_ref_end = (c == 9);
            randomize_payload();
            @(negedge sclk);
            n_checks++;
            if ({ref_en, wr_en, rd_en} !== exp_grants()) begin
                n_fail++; $display("FAIL preempt_grants c=%0d got %b want %b", c, {ref_en, wr_en, rd_en}, exp_grants());
            end
            n_checks++;
            if (dut_pins !== exp_pins()) begin
                n_fail++; $display("FAIL preempt_pins c=%0d got %h want %h", c, dut_pins, exp_pins());
            end
            if (c == 6 || c == 7 || c == 11 || c == 14) begin
                logic [2:0] want;
                want = (c == 7) ? 3'b100 : (c == 11) ? 3'b010 : 3'b000;
                n_checks++;
                if ({ref_en, wr_en, rd_en} !== want) begin
                    n_fail++; $display("FAIL preempt_seq c=%0d got %b want %b", c, {ref_en, wr_en, rd_en}, want);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_foreign_flags();
        for (int c = 0; c <= 13; c++) begin
            wr_req       = (c == 0);
            rd_req       = (c == 7);
            flag_rd_end  = (c == 3);
            flag_ref_end = (c == 4) || (c == 11);
            init_end     = (c == 5) || (c == 9);
            flag_wr_end  = (c == 6) || (c == 10);
            randomize_payload();
            @(negedge sclk);
            n_checks++;
            if (dut_pins !== exp_pins()) begin
                n_fail++; $display("FAIL foreign_pins c=%0d got %h want %h", c, dut_pins, exp_pins());
            end
            if (c == 6 || c == 12) begin
                logic [2:0] want;
                want = (c == 6) ? 3'b010 : 3'b001;
                n_checks++;
                if ({ref_en, wr_en, rd_en} !== want) begin
                    n_fail++; $display("FAIL foreign_hold c=%0d got %b want %b", c, {ref_en, wr_en, rd_en}, want);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        init_cmd = CMD_NOP; init_addr = 12'h000;
        @(posedge sclk);
        #3;
        s_rst = 1'b1;
        own = O_INIT; pin_q_m = PINS_RST;
        #1;
        n_checks++;
        if ({ref_en, wr_en, rd_en} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_grants got %b want 000", {ref_en, wr_en, rd_en});
        end
        n_checks++;
        if (dut_pins !== PINS_RST) begin
            n_fail++; $display("FAIL midrst_pins got %h want %h", dut_pins, PINS_RST);
        end
        advance();
        s_rst = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            rd_req    = 1'b1;
            wr_req    = 1'b1;
            ref_req   = (c == 2);
            init_end  = (c == 6);
            init_cmd  = 4'($urandom);
            init_addr = 12'($urandom);
            randomize_payload();
            @(negedge sclk);
            n_checks++;
            if ({ref_en, wr_en, rd_en} !== exp_grants()) begin
                n_fail++; $display("FAIL midrst_seq c=%0d got %b want %b", c, {ref_en, wr_en, rd_en}, exp_grants());
            end
            n_checks++;
            if (dut_pins !== exp_pins()) begin
                n_fail++; $display("FAIL midrst_pins c=%0d got %h want %h", c, dut_pins, exp_pins());
            end
            if (c == 6 || c == 8) begin
                logic [2:0] want;
                want = (c == 8) ? 3'b010 : 3'b000;
                n_checks++;
                if ({ref_en, wr_en, rd_en} !== want) begin
                    n_fail++; $display("FAIL midrst_init c=%0d got %b want %b", c, {ref_en, wr_en, rd_en}, want);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            ref_req      = ($urandom_range(0, 3) == 0);
            wr_req       = ($urandom_range(0, 2) == 0);
            rd_req       = ($urandom_range(0, 2) == 0);
            flag_ref_end = ($urandom_range(0, 4) == 0);
            flag_wr_end  = ($urandom_range(0, 4) == 0);
            flag_rd_end  = ($urandom_range(0, 4) == 0);
            init_end     = ($urandom_range(0, 7) == 0);
            init_cmd     = 4'($urandom);
            init_addr    = 12'($urandom);
            randomize_payload();
            @(negedge sclk);
            n_checks++;
            if ({ref_en, wr_en, rd_en} !== exp_grants()) begin
                n_fail++; $display("FAIL rand_grants c=%0d got %b want %b", c, {ref_en, wr_en, rd_en}, exp_grants());
            end
            n_checks++;
            if (dut_pins !== exp_pins()) begin
                n_fail++; $display("FAIL rand_pins c=%0d got %h want %h", c, dut_pins, exp_pins());
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_priority();
        test_preempt();
        test_foreign_flags();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
